// File: rtl/spi_mem_writer.sv
// spi_mem_writer
// Serial-to-memory write sequencer. Bytes arrive MSB first on mosi, one bit
// per sclkPosEdge strobe, framed by an active-low csN. The first byte of a
// frame selects the start address; every following byte becomes a one-clk
// write strobe to memory, after which the address auto-increments and wraps
// from depth-1 back to wrapAddr.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rstN        asynchronous active-low reset
//   sclkPosEdge one-clk strobe marking a serial-clock rising edge (synchronized)
//   csN         frame select, active low (synchronized)
//   mosi        serial data, sampled on the sclkPosEdge cycle
//   wrEn        when low, data bytes are received but discarded
//   memAddr     write address presented to memory
//   memData     write data presented to memory
//   memWe       one-clk write strobe
//   busy        high while a frame is in progress (ADDR or DATA)
//   wrapped     sticky flag, set when a write at depth-1 wraps to wrapAddr
module spi_mem_writer #(
    parameter int addrWidth = 4,
    parameter int depth     = 2 ** addrWidth,
    parameter int wrapAddr  = 0
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 sclkPosEdge,
    input  logic                 csN,
    input  logic                 mosi,
    input  logic                 wrEn,
    output logic [addrWidth-1:0] memAddr,
    output logic [7:0]           memData,
    output logic                 memWe,
    output logic                 busy,
    output logic                 wrapped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [addrWidth-1:0] lastAddr  = addrWidth'(depth - 1);
    localparam logic [addrWidth-1:0] wrapAddrL = addrWidth'(wrapAddr);

    state_t      state;
    logic [6:0]  shiftReg;
    logic [2:0]  bitCnt;
    logic [7:0]  nextByte;

    // Only seven bits need to be kept: the eighth arrives on mosi in the
    // same cycle the byte completes, so the full byte is formed on the fly.
    assign nextByte = {shiftReg, mosi};

    // Single sequencer process. The address advance is keyed off memWe
    // itself so that it happens on the edge that ends the write cycle,
    // independent of what csN or the serial side do in that cycle. memWe can
    // only be high in DATA, so the advance never collides with the address
    // load in ADDR or the wrapped clear in IDLE.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            memAddr  <= '0;
            memData  <= '0;
            memWe    <= 1'b0;
            busy     <= 1'b0;
            wrapped  <= 1'b0;
            shiftReg <= '0;
            bitCnt   <= '0;
        end else begin
            memWe <= 1'b0;

            if (memWe) begin
                if (memAddr == lastAddr) begin
                    memAddr <= wrapAddrL;
                    wrapped <= 1'b1;
                end else begin
                    memAddr <= memAddr + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    // A strobe in the frame-start cycle is deliberately ignored.
                    if (!csN) begin
                        state    <= ADDR;
                        busy     <= 1'b1;
                        bitCnt   <= '0;
                        shiftReg <= '0;
                        wrapped  <= 1'b0;
                    end
                end

                ADDR, DATA: begin
                    // csN high wins over a coincident strobe; the partial
                    // byte is simply dropped.
                    if (csN) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sclkPosEdge) begin
                        shiftReg <= nextByte[6:0];
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            if (state == ADDR) begin
                                memAddr <= nextByte[addrWidth-1:0];
                                state   <= DATA;
                            end else if (wrEn) begin
                                memData <= nextByte;
                                memWe   <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_writer.sv
// tb_spi_mem_writer
// Directed self-checking bench for spi_mem_writer (addrWidth=4, wrapAddr=3).
// Inputs change on the falling clock edge and outputs are sampled there too,
// so every comparison is half a clock away from the active edge.
module tb_spi_mem_writer;

    logic       clk;
    logic       rstN;
    logic       sclkPosEdge;
    logic       csN;
    logic       mosi;
    logic       wrEn;
    logic [3:0] memAddr;
    logic [7:0] memData;
    logic       memWe;
    logic       busy;
    logic       wrapped;

    int tests;
    int failed;
    int weCount;
    int base;
    logic [3:0] logAddr [64];
    logic [7:0] logData [64];

    spi_mem_writer #(
        .addrWidth(4),
        .depth(16),
        .wrapAddr(3)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .sclkPosEdge(sclkPosEdge),
        .csN(csN),
        .mosi(mosi),
        .wrEn(wrEn),
        .memAddr(memAddr),
        .memData(memData),
        .memWe(memWe),
        .busy(busy),
        .wrapped(wrapped)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write strobe seen by memory (one falling edge per pulse).
    always @(negedge clk) begin
        if (memWe) begin
            logAddr[weCount[5:0]] = memAddr;
            logData[weCount[5:0]] = memData;
            weCount = weCount + 1;
        end
    end

    // One serial bit with an idle clk after the strobe.
    task automatic sendBit(input logic b);
        @(negedge clk);
        mosi = b;
        sclkPosEdge = 1'b1;
        @(negedge clk);
        sclkPosEdge = 1'b0;
    endtask

    // Returns on the falling edge right after the 8th strobe was sampled,
    // which is where a data byte's memWe pulse is visible.
    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
    endtask

    task automatic startFrame();
        @(negedge clk);
        csN = 1'b0;
    endtask

    task automatic endFrame();
        @(negedge clk);
        csN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        csN = 1'b1;
        sclkPosEdge = 1'b0;
        mosi = 1'b0;
        wrEn = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (memAddr !== 4'h0) begin failed++; $display("[TB] FAIL reset_addr: got %0h want 0", memAddr); end
        tests++; if (memData !== 8'h00) begin failed++; $display("[TB] FAIL reset_data: got %0h want 0", memData); end
        tests++; if (memWe !== 1'b0) begin failed++; $display("[TB] FAIL reset_we: got %0b want 0", memWe); end
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (wrapped !== 1'b0) begin failed++; $display("[TB] FAIL reset_wrapped: got %0b want 0", wrapped); end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_write();
        base = weCount;
        startFrame();
        sendByte(8'h05);
        sendByte(8'hA3);
        tests++; if (memWe !== 1'b1) begin failed++; $display("[TB] FAIL basic_we: got %0b want 1", memWe); end
        tests++; if (memAddr !== 4'h5) begin failed++; $display("[TB] FAIL basic_addr: got %0h want 5", memAddr); end
        tests++; if (memData !== 8'hA3) begin failed++; $display("[TB] FAIL basic_data: got %0h want a3", memData); end
        @(negedge clk);
        tests++; if (memWe !== 1'b0) begin failed++; $display("[TB] FAIL basic_we_pulse: got %0b want 0", memWe); end
        tests++; if (memAddr !== 4'h6) begin failed++; $display("[TB] FAIL basic_addr_adv: got %0h want 6", memAddr); end
        tests++; if (busy !== 1'b1) begin failed++; $display("[TB] FAIL basic_busy: got %0b want 1", busy); end
        tests++; if (weCount !== base + 1) begin failed++; $display("[TB] FAIL basic_count: got %0d want %0d", weCount - base, 1); end
        endFrame();
        tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL basic_idle: got %0b want 0", busy); end
    endtask

    task automatic test_burst_wrap();
        startFrame();
        sendByte(8'h0E);
        sendByte(8'h11);
        tests++; if (memWe !== 1'b1 || memAddr !== 4'hE || memData !== 8'h11) begin failed++; $display("[TB] FAIL wrap_w0: got we=%0b %0h/%0h want we=1 e/11", memWe, memAddr, memData); end
        sendByte(8'h22);
        tests++; if (memWe !== 1'b1 || memAddr !== 4'hF || memData !== 8'h22) begin failed++; $display("[TB] FAIL wrap_w1: got we=%0b %0h/%0h want we=1 f/22", memWe, memAddr, memData); end
        tests++; if (wrapped !== 1'b0) begin failed++; $display("[TB] FAIL wrap_early: got %0b want 0", wrapped); end
        @(negedge clk);
        tests++; if (memAddr !== 4'h3) begin failed++; $display("[TB] FAIL wrap_addr: got %0h want 3", memAddr); end
        tests++; if (wrapped !== 1'b1) begin failed++; $display("[TB] FAIL wrap_flag: got %0b want 1", wrapped); end
        sendByte(8'h33);
        tests++; if (memWe !== 1'b1 || memAddr !== 4'h3 || memData !== 8'h33) begin failed++; $display("[TB] FAIL wrap_w2: got we=%0b %0h/%0h want we=1 3/33", memWe, memAddr, memData); end
        @(negedge clk);
        tests++; if (memAddr !== 4'h4) begin failed++; $display("[TB] FAIL wrap_next: got %0h want 4", memAddr); end
        endFrame();
        tests++; if (wrapped !== 1'b1) begin failed++; $display("[TB] FAIL wrap_sticky: got %0b want 1", wrapped); end
    endtask

    task automatic test_abort();
        base = weCount;
        startFrame();
        @(negedge clk);
        tests++; if (wrapped !== 1'b0 || busy !== 1'b1) begin failed++; $display("[TB] FAIL abort_start: got wrapped=%0b busy=%0b want 0/1", wrapped, busy); end
        sendByte(8'h02);
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        endFrame();
        tests++; if (busy !== 1'b0 || memAddr !== 4'h2) begin failed++; $display("[TB] FAIL abort_state: got busy=%0b addr=%0h want 0/2", busy, memAddr); end
        tests++; if (weCount !== base) begin failed++; $display("[TB] FAIL abort_nowrite: got %0d writes want 0", weCount - base); end
        startFrame();
        sendByte(8'h07);
        sendByte(8'h5A);
        tests++; if (memWe !== 1'b1 || memAddr !== 4'h7 || memData !== 8'h5A) begin failed++; $display("[TB] FAIL abort_rewrite: got we=%0b %0h/%0h want we=1 7/5a", memWe, memAddr, memData); end
        endFrame();
    endtask

    task automatic test_wren_off();
        wrEn = 1'b0;
        startFrame();
        sendByte(8'h04);
        base = weCount;
        sendByte(8'hFF);
        @(negedge clk);
        tests++; if (weCount !== base) begin failed++; $display("[TB] FAIL wren_nowrite: got %0d writes want 0", weCount - base); end
        tests++; if (memAddr !== 4'h4 || memData !== 8'h5A) begin failed++; $display("[TB] FAIL wren_hold: got %0h/%0h want 4/5a", memAddr, memData); end
        wrEn = 1'b1;
        sendByte(8'h10);
        tests++; if (memWe !== 1'b1 || memAddr !== 4'h4 || memData !== 8'h10) begin failed++; $display("[TB] FAIL wren_write: got we=%0b %0h/%0h want we=1 4/10", memWe, memAddr, memData); end
        endFrame();
    endtask

    task automatic test_cs_priority();
        startFrame();
        sendByte(8'h01);
        base = weCount;
        for (int i = 0; i < 7; i++) sendBit(1'b1);
        @(negedge clk);
        csN = 1'b1;
        sclkPosEdge = 1'b1;
        mosi = 1'b1;
        @(negedge clk);
        sclkPosEdge = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || weCount !== base || memAddr !== 4'h1) begin failed++; $display("[TB] FAIL cs_priority: got busy=%0b writes=%0d addr=%0h want 0/0/1", busy, weCount - base, memAddr); end
        startFrame();
        sendByte(8'hF9);
        tests++; if (memAddr !== 4'h9) begin failed++; $display("[TB] FAIL addr_upper: got %0h want 9", memAddr); end
        endFrame();
    endtask

    task automatic test_back_to_back();
        logic [15:0] word;
        word = 16'hC33C;
        startFrame();
        sendByte(8'h00);
        base = weCount;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            sclkPosEdge = 1'b1;
            mosi = word[i];
        end
        @(negedge clk);
        sclkPosEdge = 1'b0;
        @(negedge clk);
        tests++; if (weCount !== base + 2) begin failed++; $display("[TB] FAIL b2b_count: got %0d want 2", weCount - base); end
        tests++; if (logAddr[base[5:0]] !== 4'h0 || logData[base[5:0]] !== 8'hC3) begin failed++; $display("[TB] FAIL b2b_first: got %0h/%0h want 0/c3", logAddr[base[5:0]], logData[base[5:0]]); end
        tests++; if (logAddr[6'(base + 1)] !== 4'h1 || logData[6'(base + 1)] !== 8'h3C) begin failed++; $display("[TB] FAIL b2b_second: got %0h/%0h want 1/3c", logAddr[6'(base + 1)], logData[6'(base + 1)]); end
        tests++; if (memAddr !== 4'h2) begin failed++; $display("[TB] FAIL b2b_addr: got %0h want 2", memAddr); end
        endFrame();
    endtask

    task automatic test_reset_during_we();
        startFrame();
        sendByte(8'h0C);
        sendByte(8'h77);
        tests++; if (memWe !== 1'b1) begin failed++; $display("[TB] FAIL rst_we_pre: got %0b want 1", memWe); end
        #2;
        rstN = 1'b0;
        #1;
        tests++; if (memWe !== 1'b0 || memAddr !== 4'h0) begin failed++; $display("[TB] FAIL rst_we: got we=%0b addr=%0h want 0/0", memWe, memAddr); end
        tests++; if (busy !== 1'b0 || memData !== 8'h00) begin failed++; $display("[TB] FAIL rst_we_state: got busy=%0b data=%0h want 0/0", busy, memData); end
        @(negedge clk);
        csN = 1'b1;
        rstN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        weCount = 0;
        test_reset();
        test_basic_write();
        test_burst_wrap();
        test_abort();
        test_wren_off();
        test_cs_priority();
        test_back_to_back();
        test_reset_during_we();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spi_mem_writer.md
Name: spi_mem_writer

Overview:
Serial-to-memory write sequencer. It is the write-side counterpart of the program counter that steps memory read addresses on byte boundaries. It deserializes MOSI bytes framed by csN. The first byte of each frame sets the start address. Each following byte is written to memory as a one-cycle write strobe, with auto-increment and wrap to a loop address.

Parameters:
addrWidth, 4, memory address width; legal range 1..8
depth, 2**addrWidth, number of memory words
wrapAddr, 0, address loaded after a write at depth-1; must be < depth

Ports:
clk  input  1  system clock; all logic on posedge
rstN  input  1  asynchronous active-low reset
sclkPosEdge  input  1  one-clk strobe marking a serial-clock rising edge, already synchronized to clk
csN  input  1  frame select, active low, already synchronized to clk
mosi  input  1  serial data, MSB first, valid on the sclkPosEdge cycle
wrEn  input  1  write enable; when 0, data bytes are received and discarded, no strobe, no address advance
memAddr  output  addrWidth  write address presented to memory
memData  output  8  write data
memWe  output  1  one-clk write strobe
busy  output  1  high while in ADDR or DATA state
wrapped  output  1  sticky; set when a write at depth-1 wraps to wrapAddr

Behaviour:
- Reset (rstN low, async): state IDLE; memAddr=0, memData=0, memWe=0, busy=0, wrapped=0; shift register=0, bitCnt=0.
- States: IDLE, ADDR, DATA. busy = (state != IDLE), registered.
- IDLE: if csN==0, go to ADDR next edge, clear bitCnt and shift register, clear wrapped. A sclkPosEdge in this cycle is ignored (one-clk setup).
- ADDR/DATA: if csN==1, go to IDLE next edge. csN high has priority over sclkPosEdge in the same cycle. The partial byte is discarded and no write occurs. memAddr is held.
- ADDR/DATA with csN==0 and sclkPosEdge==1: shift <= {shift[6:0], mosi}, bitCnt <= bitCnt+1 (3-bit, wraps 7->0).
- Byte completion is sclkPosEdge with bitCnt==7. Byte value = {shift[6:0], mosi}.
- Byte completion in ADDR: memAddr <= byte[addrWidth-1:0] (upper bits ignored); go to DATA; no write.
- Byte completion in DATA with wrEn==1: memData <= byte and memWe <= 1 on the same edge. The write is therefore seen at memory one clk after the 8th strobe, with memAddr equal to the target address.
- Byte completion in DATA with wrEn==0: memData is unchanged and memWe stays 0.
- memWe is high for exactly one clk. On the edge that ends a memWe cycle, the address advances:
  - memAddr==depth-1: memAddr <= wrapAddr and wrapped <= 1.
  - otherwise: memAddr <= memAddr+1.
- If csN rises during the memWe cycle, the write and the address advance still complete, then the block goes to IDLE.
- Back-to-back bytes: the minimum spacing is 8 sclkPosEdge strobes. A strobe in the memWe cycle is accepted as bit 0 of the next byte.
- memData holds its last value between writes. wrapped stays set until reset or the next frame start.
- Reset mid-frame: immediate return to reset values; no memWe is generated.

Test Plan:
- Reset, then frame: csN low, bytes 0x05, 0xA3 with wrEn=1 -> after the 16th strobe, one memWe pulse with memAddr=5 and memData=0xA3; then memAddr=6 and busy=1; csN high -> busy=0.
- Burst wrap with wrapAddr=3: address byte 0x0E, then data 0x11, 0x22, 0x33 -> writes at 14 (0x11), 15 (0x22), 3 (0x33); wrapped=1 after the write at 15.
- Abort: address byte 0x02, then 5 data bits, then csN high -> no memWe, memAddr=2, IDLE. A new frame at address 0x07 with data 0x5A writes 0x5A at 7 and clears wrapped.
- wrEn=0: address 0x04, data 0xFF -> no memWe, memAddr stays 4. Set wrEn=1, data 0x10 -> write 0x10 at 4.
- Edge cases:
  - sclkPosEdge in the same cycle csN rises is ignored.
  - Address byte 0xF9 with addrWidth=4 -> memAddr=9.
  - rstN asserted during a memWe cycle -> memWe=0 and memAddr=0 immediately.
